// File: rtl/sha256_pkg.sv
// +----------------------------------------------------------------------------+
// | sha256_pkg                                                                 |
// | Shared constants, padder state encoding and block-count helper.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sha256_pkg;

  localparam int          WORDS_PER_BLOCK = 16;
  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    PAD  = 3'd4,
    DONE = 3'd5
  } padder_state_e;

  // Message bits plus the mandatory 1 bit and 64-bit length, rounded up to 512.
  function automatic int num_blocks(input int num_words);
    return (num_words * 32 + 65 + 511) / 512;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_msg_padder.sv
// +----------------------------------------------------------------------------+
// | sha256_msg_padder                                                          |
// | Reads a message from memory and streams it SHA-256 padded, 16 words per    |
// | block. Define SHA256_PAD_BYTESWAP_EN to byte-reverse message words.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_block_last,
  output logic              out_msg_last,
  output logic              busy,
  output logic              done
);

  localparam int          c_total     = WORDS_PER_BLOCK * num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] c_num_words = 16'(NUM_OF_WORDS);
  localparam logic [15:0] c_last_idx  = 16'(c_total - 1);
  localparam logic [31:0] c_len_word  = 32'(NUM_OF_WORDS * 32);

  padder_state_e     r_state;
  padder_state_e     w_next_state;
  logic [15:0]       r_k;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       w_k_next;
  logic              w_xfer;
  logic              w_more_msg;
  logic              w_at_last;

  assign w_k_next   = r_k + 16'd1;
  assign w_xfer     = out_valid && out_ready;
  assign w_more_msg = (r_state == EMIT) && (w_k_next < c_num_words);
  assign w_at_last  = (r_k == c_last_idx);

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  // Word content for indices at or beyond the end of the message.
  function automatic logic [31:0] pad_word_at(input logic [15:0] idx);
    if (idx == c_num_words)
      return PAD_WORD;
    else if (idx == c_last_idx)
      return c_len_word;
    else
      return 32'h0;
  endfunction

  function automatic logic [31:0] fmt_msg_word(input logic [31:0] w);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = READ;
      READ: w_next_state = WAIT;
      WAIT: w_next_state = EMIT;
      EMIT, PAD: begin
        if (w_xfer) begin
          if (w_more_msg)
            w_next_state = READ;
          else if (w_at_last)
            w_next_state = DONE;
          else
            w_next_state = PAD;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k            <= 16'd0;
      r_base         <= '0;
      mem_addr       <= '0;
      out_data       <= 32'h0;
      out_valid      <= 1'b0;
      out_block_last <= 1'b0;
      out_msg_last   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= message_addr;
            mem_addr <= message_addr;
            r_k      <= 16'd0;
          end
        end
        WAIT: begin
          out_data       <= fmt_msg_word(mem_read_data);
          out_valid      <= 1'b1;
          out_block_last <= (r_k[3:0] == 4'hF);
          out_msg_last   <= w_at_last;
        end
        EMIT, PAD: begin
          if (w_xfer) begin
            if (w_more_msg) begin
              r_k            <= w_k_next;
              mem_addr       <= r_base + ADDR_W'(w_k_next);
              out_valid      <= 1'b0;
              out_block_last <= 1'b0;
              out_msg_last   <= 1'b0;
            end else if (w_at_last) begin
              out_valid      <= 1'b0;
              out_block_last <= 1'b0;
              out_msg_last   <= 1'b0;
            end else begin
              // Padding words are generated locally; valid stays high.
              r_k            <= w_k_next;
              out_data       <= pad_word_at(w_k_next);
              out_block_last <= (w_k_next[3:0] == 4'hF);
              out_msg_last   <= (w_k_next == c_last_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench: three padder instances (N=20, 13, 14) against a
// scoreboard of expected padded words built from a synthetic memory image.
`default_nettype none

module tb_sha256_msg_padder;

  localparam int NI = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        blast;
    logic        mlast;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start          [NI];
  logic [15:0] message_addr   [NI];
  logic [15:0] mem_addr       [NI];
  logic [31:0] mem_rd         [NI];
  logic [31:0] out_data       [NI];
  logic        out_valid      [NI];
  logic        out_ready      [NI];
  logic        out_block_last [NI];
  logic        out_msg_last   [NI];
  logic        busy           [NI];
  logic        done           [NI];

  exp_t q        [NI][$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   xfers    [NI] = '{default: 0};
  int   done_chk [NI] = '{default: 0};
  logic stalled  [NI] = '{default: 1'b0};
  exp_t held     [NI];
  exp_t e_mon;

  always #5 clk = ~clk;

  function automatic int nw(input int i);
    return (i == 0) ? 20 : (i == 1) ? 13 : 14;
  endfunction

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0100) return 32'h6162_6380;
    return {a, ~a} ^ 32'h3c5a_9617;
  endfunction

  function automatic logic [31:0] exp_msg(input logic [31:0] w);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sha256_msg_padder #(
      .NUM_OF_WORDS((gi == 0) ? 20 : (gi == 1) ? 13 : 14),
      .ADDR_W      (16)
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start[gi]),
      .message_addr  (message_addr[gi]),
      .mem_addr      (mem_addr[gi]),
      .mem_read_data (mem_rd[gi]),
      .out_data      (out_data[gi]),
      .out_valid     (out_valid[gi]),
      .out_ready     (out_ready[gi]),
      .out_block_last(out_block_last[gi]),
      .out_msg_last  (out_msg_last[gi]),
      .busy          (busy[gi]),
      .done          (done[gi])
    );
  end

  // Synchronous-read memory: data appears the cycle after the address is registered.
  always @(posedge clk)
    for (int i = 0; i < NI; i++) mem_rd[i] <= mem_fn(mem_addr[i]);

  task automatic check(input string tag, input int idx, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  // Total padded length: smallest multiple of 16 words holding N + 1 + 2 words.
  task automatic push_run(input int i, input logic [15:0] base);
    int   n;
    int   total;
    exp_t e;
    n     = nw(i);
    total = ((n + 3 + 15) / 16) * 16;
    for (int k = 0; k < total; k++) begin
      if (k < n)               e.data = exp_msg(mem_fn(base + 16'(k)));
      else if (k == n)         e.data = 32'h8000_0000;
      else if (k == total - 1) e.data = 32'(n * 32);
      else                     e.data = 32'h0;
      e.blast = (k % 16 == 15);
      e.mlast = (k == total - 1);
      q[i].push_back(e);
    end
  endtask

  task automatic do_start(input int i, input logic [15:0] base);
    @(posedge clk); #1;
    start[i] = 1'b1;
    message_addr[i] = base;
    @(posedge clk); #1;
    start[i] = 1'b0;
    message_addr[i] = ~base;
  endtask

  task automatic wait_done(input int i, input bit rand_ready, input string tag);
    int cyc;
    cyc = 0;
    while (!done[i] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (rand_ready) out_ready[i] = ($urandom_range(0, 2) != 0);
    end
    check(tag, i, {63'b0, done[i]}, 64'd1);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    check("queue_empty", i, 64'(q[i].size()), 64'd0);
  endtask

  task automatic check_reset(input int i);
    check("reset_outputs", i,
          64'({out_data[i], out_valid[i], out_block_last[i], out_msg_last[i],
               busy[i], done[i], mem_addr[i]}), 64'd0);
  endtask

  // Scoreboard monitor, sampled mid-cycle: a handshake at the next rising edge
  // is exactly out_valid && out_ready seen here.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        stalled[i]  = 1'b0;
        done_chk[i] = 0;
      end else begin
        if (done_chk[i] == 1) begin
          check("done_pulse", i, {63'b0, done[i]}, 64'd1);
          done_chk[i] = 2;
        end else if (done_chk[i] == 2) begin
          check("done_drop", i, {63'b0, done[i]}, 64'd0);
          done_chk[i] = 0;
        end
        if (stalled[i])
          check("stall_hold", i, 64'({out_valid[i], out_data[i], out_block_last[i], out_msg_last[i]}),
                64'({1'b1, held[i]}));
        if (out_valid[i] && out_ready[i]) begin
          if (q[i].size() == 0) begin
            check("extra_word", i, 64'd0, 64'd1);
          end else begin
            e_mon = q[i].pop_front();
            check("word", i, 64'({out_data[i], out_block_last[i], out_msg_last[i]}), 64'(e_mon));
            xfers[i]++;
            if (e_mon.mlast) done_chk[i] = 1;
          end
        end
        stalled[i] = out_valid[i] && !out_ready[i];
        held[i]    = {out_data[i], out_block_last[i], out_msg_last[i]};
      end
    end
  end

  initial begin
    int x0;
    int cyc;
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i]        = 1'b0;
      message_addr[i] = 16'h0;
      out_ready[i]    = 1'b1;
    end
    #2;
    for (int i = 0; i < NI; i++) check_reset(i);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // All three lengths in parallel; N=13 covers the byte-swap test word at 0x100.
    push_run(0, 16'h0010);
    push_run(1, 16'h00F8);
    push_run(2, 16'h0200);
    @(posedge clk); #1;
    start[0] = 1'b1; message_addr[0] = 16'h0010;
    start[1] = 1'b1; message_addr[1] = 16'h00F8;
    start[2] = 1'b1; message_addr[2] = 16'h0200;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      message_addr[i] = 16'hDEAD;
    end
    check("busy_after_start", 0, {63'b0, busy[0]}, 64'd1);
    wait_done(1, 1'b0, "done_n13");
    wait_done(2, 1'b0, "done_n14");
    wait_done(0, 1'b0, "done_n20");

    // Random backpressure with address wrap.
    push_run(0, 16'hFFF8);
    do_start(0, 16'hFFF8);
    wait_done(0, 1'b1, "done_backpressure");

    // A start while busy with a different address must be ignored.
    push_run(0, 16'h0040);
    do_start(0, 16'h0040);
    repeat (5) @(posedge clk);
    do_start(0, 16'h0800);
    wait_done(0, 1'b0, "done_start_ignored");

    // Asynchronous reset while the fifth word is presented.
    push_run(0, 16'h0300);
    do_start(0, 16'h0300);
    x0  = xfers[0];
    cyc = 0;
    while (!((xfers[0] - x0) == 4 && out_valid[0]) && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("reached_word4", 0, 64'(xfers[0] - x0), 64'd4);
    reset_n = 1'b0;
    #1;
    check_reset(0);
    q[0].delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_run(0, 16'h0300);
    do_start(0, 16'h0300);
    wait_done(0, 1'b0, "done_after_reset");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
